fc_layer_ctrl: RTL and testbench

Sequencer for one fully-connected layer evaluation over the FC register file.
- For each output neuron j, it walks the INPUT_SIZE activations held in the register file and the matching weights from weight memory, accumulating signed products.
- It then writes the requantized result and its positive flag back into the register file through the file's write port.
- It sits between the top-level layer scheduler (start/done) and the FC register file plus weight ROM.

---
 rtl/fc_layer_ctrl.sv | 129 ++++++++++++
 tb/tb_fc_layer_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/fc_layer_ctrl.sv
// Fully-connected layer sequencer. For each output neuron it multiply-accumulates the
// activations against their weights, then writes the requantized result back to the register file.
module fc_layer_ctrl #(
  parameter int BITWIDTH    = 8,
  parameter int INPUT_SIZE  = 7,
  parameter int OUTPUT_SIZE = 5,
  parameter int WADDR_W     = 6,
  parameter int SHIFT       = 4,
  parameter int RELU        = 1
) (
  input  logic                       clk_i,
  input  logic                       reset,
  input  logic                       start_i,
  input  logic [4:0]                 in_base_i,
  input  logic [4:0]                 out_base_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [4:0]                 rd_addr_o,
  input  logic [31:0]                rd_data_i,
  output logic [WADDR_W-1:0]         w_addr_o,
  input  logic signed [BITWIDTH-1:0] w_data_i,
  output logic [4:0]                 addr_o,
  output logic [31:0]                data_o,
  output logic                       RegWrite_o,
  output logic                       is_pos_o
);

  localparam int AccW = 2*BITWIDTH + 4;
  localparam int IW   = $clog2(INPUT_SIZE + 1);
  localparam int JW   = $clog2(OUTPUT_SIZE + 1);
  localparam logic [IW-1:0] LastI = IW'(INPUT_SIZE - 1);
  localparam logic [JW-1:0] LastJ = JW'(OUTPUT_SIZE - 1);
  localparam logic signed [AccW-1:0] SatMax = AccW'((1 << (BITWIDTH-1)) - 1);
  localparam logic signed [AccW-1:0] SatMin = AccW'(-(1 << (BITWIDTH-1)));

  typedef enum logic [2:0] {IDLE, CLR, MAC, WR, DONE} state_t;

  state_t                    r_state, w_nextState;
  logic [IW-1:0]             r_i;
  logic [JW-1:0]             r_j;
  logic signed [AccW-1:0]    r_acc;
  logic [4:0]                r_inBase, r_outBase, r_rdAddr;
  logic [WADDR_W-1:0]        r_wAddr;

  logic signed [BITWIDTH-1:0]   w_act;
  logic signed [2*BITWIDTH-1:0] w_product;
  logic signed [AccW-1:0]       w_productExt, w_shifted;
  logic signed [BITWIDTH-1:0]   w_res;
  logic                         w_unusedRdHigh;

  assign w_act          = rd_data_i[BITWIDTH-1:0];
  assign w_unusedRdHigh = ^rd_data_i[31:BITWIDTH];
  assign w_product      = $signed({{BITWIDTH{w_act[BITWIDTH-1]}}, w_act}) *
                          $signed({{BITWIDTH{w_data_i[BITWIDTH-1]}}, w_data_i});
  assign w_productExt   = {{(AccW-2*BITWIDTH){w_product[2*BITWIDTH-1]}}, w_product};
  assign w_shifted      = r_acc >>> SHIFT;

  always_ff @(posedge clk_i or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (start_i) w_nextState = CLR;
      CLR:     w_nextState = MAC;
      MAC:     if (r_i == LastI) w_nextState = WR;
      WR:      w_nextState = (r_j == LastJ) ? DONE : CLR;
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Read and weight addresses are registered so they hold their last value outside MAC.
  always_ff @(posedge clk_i or negedge reset) begin
    if (!reset) begin
      r_i       <= '0;
      r_j       <= '0;
      r_acc     <= '0;
      r_inBase  <= '0;
      r_outBase <= '0;
      r_rdAddr  <= '0;
      r_wAddr   <= '0;
    end else begin
      case (r_state)
        IDLE: if (start_i) begin
          r_inBase  <= in_base_i;
          r_outBase <= out_base_i;
          r_j       <= '0;
        end
        CLR: begin
          r_acc    <= '0;
          r_i      <= '0;
          r_rdAddr <= r_inBase;
          r_wAddr  <= WADDR_W'(int'(r_j) * INPUT_SIZE);
        end
        MAC: begin
          r_acc <= r_acc + w_productExt;
          if (r_i != LastI) begin
            r_i      <= r_i + 1'b1;
            r_rdAddr <= r_rdAddr + 5'd1;
            r_wAddr  <= r_wAddr + 1'b1;
          end
        end
        WR: if (r_j != LastJ) r_j <= r_j + 1'b1;
        default: ;
      endcase
    end
  end

  // Requantize: shift, saturate to the signed result range, then optional ReLU.
  always_comb begin
    w_res = w_shifted[BITWIDTH-1:0];
    if (w_shifted > SatMax)      w_res = SatMax[BITWIDTH-1:0];
    else if (w_shifted < SatMin) w_res = SatMin[BITWIDTH-1:0];
    if (RELU != 0 && w_res[BITWIDTH-1]) w_res = '0;
  end

  assign busy_o     = (r_state != IDLE);
  assign done_o     = (r_state == DONE);
  assign RegWrite_o = (r_state == WR);
  assign rd_addr_o  = r_rdAddr;
  assign w_addr_o   = r_wAddr;
  assign addr_o     = RegWrite_o ? r_outBase + 5'(r_j) : 5'd0;
  assign data_o     = RegWrite_o ? {{(32-BITWIDTH){w_res[BITWIDTH-1]}}, w_res} : 32'd0;
  assign is_pos_o   = RegWrite_o && !w_res[BITWIDTH-1] && (w_res != '0);

endmodule

// File: tb/tb_fc_layer_ctrl.sv
// Randomized self-checking bench for fc_layer_ctrl: two instances (ReLU on/off) share stimulus
// and are compared against a layer-level arithmetic model plus the expected cycle schedule.
module tb_fc_layer_ctrl;

  localparam int BW = 8, IN = 7, OUT = 5, WAW = 6, SH = 4, NW = IN*OUT;
  localparam int LAT = OUT*(IN+2) + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstN, start;
  logic [4:0] inBase, outBase;

  logic busyA, doneA, regWriteA, isPosA, busyB, doneB, regWriteB, isPosB;
  logic [4:0] rdAddrA, addrA, rdAddrB, addrB;
  logic [31:0] rdDataA, dataA, rdDataB, dataB;
  logic [WAW-1:0] wAddrA, wAddrB;
  logic signed [BW-1:0] wDataA, wDataB;

  logic [31:0] regs [2][32];
  logic signed [BW-1:0] wrom [NW];
  logic [37:0] wrQ0[$], wrQ1[$];
  int expAddr [2][OUT];
  int expData [2][OUT];
  int totalChecks = 0, badChecks = 0;

  assign rdDataA = regs[0][rdAddrA];
  assign rdDataB = regs[1][rdAddrB];
  assign wDataA  = (int'(wAddrA) < NW) ? wrom[wAddrA] : '0;
  assign wDataB  = (int'(wAddrB) < NW) ? wrom[wAddrB] : '0;

  fc_layer_ctrl #(.BITWIDTH(BW), .INPUT_SIZE(IN), .OUTPUT_SIZE(OUT), .WADDR_W(WAW),
                  .SHIFT(SH), .RELU(1)) dutA (
    .clk_i(clk), .reset(rstN), .start_i(start), .in_base_i(inBase), .out_base_i(outBase),
    .busy_o(busyA), .done_o(doneA), .rd_addr_o(rdAddrA), .rd_data_i(rdDataA),
    .w_addr_o(wAddrA), .w_data_i(wDataA), .addr_o(addrA), .data_o(dataA),
    .RegWrite_o(regWriteA), .is_pos_o(isPosA));

  fc_layer_ctrl #(.BITWIDTH(BW), .INPUT_SIZE(IN), .OUTPUT_SIZE(OUT), .WADDR_W(WAW),
                  .SHIFT(SH), .RELU(0)) dutB (
    .clk_i(clk), .reset(rstN), .start_i(start), .in_base_i(inBase), .out_base_i(outBase),
    .busy_o(busyB), .done_o(doneB), .rd_addr_o(rdAddrB), .rd_data_i(rdDataB),
    .w_addr_o(wAddrB), .w_data_i(wDataB), .addr_o(addrB), .data_o(dataB),
    .RegWrite_o(regWriteB), .is_pos_o(isPosB));

  // The register file captures writes on the falling edge; every write is also logged.
  always @(negedge clk) begin
    if (regWriteA) begin
      regs[0][addrA] = dataA;
      wrQ0.push_back({isPosA, addrA, dataA});
    end
    if (regWriteB) begin
      regs[1][addrB] = dataB;
      wrQ1.push_back({isPosB, addrB, dataB});
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    totalChecks++;
    if (got !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s got=%0h want=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Whole-layer reference: dot products on a copy of the register file, results written
  // back in order so later neurons see earlier in-place overwrites.
  task automatic buildModel(input logic [4:0] ib, input logic [4:0] ob);
    logic [31:0] mdl [2][32];
    int sum, res, idx;
    for (int k = 0; k < 2; k++)
      for (int a = 0; a < 32; a++) mdl[k][a] = regs[k][a];
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < OUT; j++) begin
        sum = 0;
        for (int i = 0; i < IN; i++) begin
          idx = (int'(ib) + i) % 32;
          sum += int'($signed(mdl[k][idx][BW-1:0])) * int'(wrom[j*IN + i]);
        end
        res = sum >>> SH;
        if (res > 127)  res = 127;
        if (res < -128) res = -128;
        if (k == 0 && res < 0) res = 0;
        expAddr[k][j] = (int'(ob) + j) % 32;
        expData[k][j] = res;
        mdl[k][expAddr[k][j]] = 32'(res);
      end
    end
  endtask

  task automatic checkWrites(input int k, input int nExp);
    logic [37:0] e;
    int n;
    n = (k == 0) ? wrQ0.size() : wrQ1.size();
    checkOutput(k == 0 ? "wrCountA" : "wrCountB", 32'(n), 32'(nExp));
    for (int j = 0; j < nExp && j < n; j++) begin
      e = (k == 0) ? wrQ0[j] : wrQ1[j];
      checkOutput(k == 0 ? "wrAddrA" : "wrAddrB", 32'(e[36:32]), 32'(expAddr[k][j]));
      checkOutput(k == 0 ? "wrDataA" : "wrDataB", e[31:0], 32'(expData[k][j]));
      checkOutput(k == 0 ? "isPosA" : "isPosB", 32'(e[37]), 32'(expData[k][j] > 0));
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_busy"}, 32'({busyA, busyB}), 32'd0);
    checkOutput({tag, "_done"}, 32'({doneA, doneB}), 32'd0);
    checkOutput({tag, "_we"}, 32'({regWriteA, regWriteB}), 32'd0);
    checkOutput({tag, "_rdAddr"}, 32'({rdAddrA, rdAddrB}), 32'd0);
    checkOutput({tag, "_wAddr"}, 32'({wAddrA, wAddrB}), 32'd0);
    checkOutput({tag, "_addr"}, 32'({addrA, addrB}), 32'd0);
    checkOutput({tag, "_data"}, dataA | dataB, 32'd0);
    checkOutput({tag, "_isPos"}, 32'({isPosA, isPosB}), 32'd0);
  endtask

  // One layer run. Cycle 0 is the start cycle; cycle t>=1 belongs to neuron (t-1)/9,
  // phase (t-1)%9: 0 clear, 1..7 MAC, 8 write; cycle LAT is the done cycle.
  task automatic applyStimulus(input logic [4:0] ib, input logic [4:0] ob,
                               input bit pulseBusy, input int abortAt);
    int n, p, nExp;
    buildModel(ib, ob);
    wrQ0.delete();
    wrQ1.delete();
    nExp = OUT;
    @(negedge clk);
    inBase = ib; outBase = ob; start = 1'b1;
    for (int t = 1; t <= LAT + 1; t++) begin
      @(negedge clk);
      if (t == 1) begin
        inBase = 5'($urandom);
        outBase = 5'($urandom);
      end
      if (abortAt != 0 && t == abortAt) begin
        rstN = 1'b0;
        #1;
        checkAllZero("abort");
        repeat (2) begin
          @(negedge clk);
          checkOutput("abortNoWrite", 32'({regWriteA, regWriteB}), 32'd0);
        end
        rstN = 1'b1;
        nExp = 0;
        for (int j = 0; j < OUT; j++) if (9*(j+1) < abortAt) nExp++;
        break;
      end
      n = (t - 1) / 9;
      p = (t - 1) % 9;
      checkOutput("busy", 32'(busyA), 32'(t <= LAT));
      checkOutput("busyB", 32'(busyB), 32'(t <= LAT));
      checkOutput("done", 32'(doneA), 32'(t == LAT));
      checkOutput("weA", 32'(regWriteA), 32'(t < LAT && p == 8));
      checkOutput("weB", 32'(regWriteB), 32'(t < LAT && p == 8));
      if (t < LAT && p >= 1 && p <= 7) begin
        checkOutput("rdAddr", 32'(rdAddrA), 32'((int'(ib) + p - 1) % 32));
        checkOutput("wAddr", 32'(wAddrA), 32'(n*IN + p - 1));
      end
      start = pulseBusy && (t == 5 || t == 20 || t == LAT);
    end
    start = 1'b0;
    @(negedge clk);
    checkWrites(0, nExp);
    checkWrites(1, nExp);
  endtask

  task automatic fillRegs(input int mode, input int val);
    for (int a = 0; a < 32; a++) begin
      regs[0][a] = {24'($urandom), (mode == 0) ? 8'(val) : 8'($urandom)};
      regs[1][a] = regs[0][a];
    end
  endtask

  task automatic fillWeights(input int mode, input int val);
    for (int w = 0; w < NW; w++) wrom[w] = (mode == 0) ? 8'(val) : 8'($urandom);
  endtask

  initial begin
    int weSeen, busySeen;
    rstN = 1'b0; start = 1'b0; inBase = '0; outBase = '0;
    fillRegs(1, 0);
    fillWeights(1, 0);
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    rstN = 1'b1;
    weSeen = 0; busySeen = 0;
    repeat (20) begin
      @(negedge clk);
      weSeen += int'(regWriteA | regWriteB);
      busySeen += int'(busyA | busyB);
    end
    checkOutput("idleWrites", 32'(weSeen), 32'd0);
    checkOutput("idleBusy", 32'(busySeen), 32'd0);

    $display("[TB] unit layer");
    fillRegs(0, 1); fillWeights(0, 16);
    applyStimulus(5'd0, 5'd10, 1'b0, 0);

    $display("[TB] saturation and relu");
    fillRegs(0, 127); fillWeights(0, 127);
    applyStimulus(5'd0, 5'd20, 1'b0, 0);
    fillRegs(0, 127); fillWeights(0, -127);
    applyStimulus(5'd0, 5'd20, 1'b0, 0);

    $display("[TB] address wrap with overlap");
    fillRegs(1, 0); fillWeights(1, 0);
    applyStimulus(5'd30, 5'd29, 1'b0, 0);

    $display("[TB] start while busy");
    fillRegs(1, 0); fillWeights(1, 0);
    applyStimulus(5'($urandom), 5'($urandom), 1'b1, 0);

    $display("[TB] reset mid-run");
    fillRegs(1, 0); fillWeights(1, 0);
    applyStimulus(5'd3, 5'd16, 1'b0, 22);
    applyStimulus(5'd3, 5'd16, 1'b0, 0);

    $display("[TB] random layers");
    for (int r = 0; r < 4; r++) begin
      fillRegs(1, 0); fillWeights(1, 0);
      applyStimulus(5'($urandom), 5'($urandom), r[0], 0);
    end

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
